// File: rtl/load_image_writer.sv
// load_image_writer: dumps a program image as ASCII load-file text.
// Ports: clock/reset (sync, active-high), start + dataOffset/initPC/
//   wordCount request, memRdEn/memAddr/memData byte read port (1-cycle
//   latency), charOut/charValid/charReady char stream, busy, done.
module load_image_writer #(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       dataOffset,
  input  logic [15:0]       initPC,
  input  logic [15:0]       wordCount,
  output logic              memRdEn,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [7:0]        memData,
  output logic [7:0]        charOut,
  output logic              charValid,
  input  logic              charReady,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE, HDR_SYM, HDR_DIG, HDR_NL,
    RD_HI, RD_LO, RD_WAIT,
    W_SYM, W_DIG, W_NL, FIN
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       pc_q, pc_d;
  logic [15:0]       wc_q, wc_d;
  logic [15:0]       idx_q, idx_d;
  logic              hdr_q, hdr_d;
  logic [7:0]        hi_q, hi_d;
  // Value being printed, top-aligned so [17:15] is the next digit.
  logic [17:0]       sh_q, sh_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        chr_q, chr_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              acc;
  logic [7:0]        dchr;
  logic [15:0]       idx_n;

  function automatic logic [ADDR_W-1:0] baddr(
    input logic [15:0] w,
    input logic        b
  );
    // Byte address 2w+b, wrapping modulo 2^ADDR_W.
    baddr = ADDR_W'({w, b});
  endfunction

  assign acc   = vld_q && charReady;
  assign dchr  = 8'h30 + {5'b0, sh_q[17:15]};
  assign idx_n = idx_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wc_d    = wc_q;
    idx_d   = idx_q;
    hdr_d   = hdr_q;
    hi_d    = hi_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    chr_d   = chr_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = initPC;
          wc_d    = wordCount;
          idx_d   = '0;
          hdr_d   = 1'b0;
          sh_d    = {2'b0, dataOffset};
          chr_d   = 8'h2A;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = HDR_SYM;
        end
      end
      HDR_SYM, W_SYM: begin
        if (acc) begin
          chr_d   = dchr;
          sh_d    = sh_q << 3;
          cnt_d   = '0;
          state_d = (state_q == HDR_SYM) ? HDR_DIG : W_DIG;
        end
      end
      HDR_DIG, W_DIG: begin
        if (acc) begin
          if (cnt_q == 3'd5) begin
            chr_d   = 8'h0A;
            state_d = (state_q == HDR_DIG) ? HDR_NL : W_NL;
          end else begin
            chr_d = dchr;
            sh_d  = sh_q << 3;
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      HDR_NL: begin
        if (acc) begin
          if (!hdr_q) begin
            hdr_d   = 1'b1;
            sh_d    = {2'b0, pc_q};
            chr_d   = 8'h40;
            state_d = HDR_SYM;
          end else if (wc_q == 16'd0) begin
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            vld_d   = 1'b0;
            rd_d    = 1'b1;
            addr_d  = baddr(idx_q, 1'b0);
            state_d = RD_HI;
          end
        end
      end
      RD_HI: begin
        addr_d  = baddr(idx_q, 1'b1);
        state_d = RD_LO;
      end
      RD_LO: begin
        // Data for the even (high) byte lands this cycle.
        hi_d    = memData;
        rd_d    = 1'b0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        sh_d    = {2'b0, hi_q, memData};
        chr_d   = 8'h2D;
        vld_d   = 1'b1;
        state_d = W_SYM;
      end
      W_NL: begin
        if (acc) begin
          idx_d = idx_n;
          vld_d = 1'b0;
          if (idx_n == wc_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            rd_d    = 1'b1;
            addr_d  = baddr(idx_n, 1'b0);
            state_d = RD_HI;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wc_q    <= '0;
      idx_q   <= '0;
      hdr_q   <= 1'b0;
      hi_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      chr_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wc_q    <= wc_d;
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      hi_q    <= hi_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      chr_q   <= chr_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign memRdEn   = rd_q;
  assign memAddr   = addr_q;
  assign charOut   = chr_q;
  assign charValid = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_load_image_writer.sv
// tb_load_image_writer: directed bench for load_image_writer with a
// string-level reference model of the dump text and read addresses.
module tb_load_image_writer;
  localparam int AW  = 8;
  localparam int MSZ = 1 << AW;

  logic          clock = 0;
  logic          reset = 1;
  logic          start = 0;
  logic [15:0]   dataOffset = 0;
  logic [15:0]   initPC = 0;
  logic [15:0]   wordCount = 0;
  logic          memRdEn;
  logic [AW-1:0] memAddr;
  logic [7:0]    memData = 0;
  logic [7:0]    charOut;
  logic          charValid;
  logic          charReady = 1;
  logic          busy;
  logic          done;

  logic [7:0] mem [MSZ];
  logic [7:0] q_exp [$];
  int         q_addr [$];
  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  bit         bp = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_char = 0;
  string      s;

  load_image_writer #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dataOffset(dataOffset), .initPC(initPC),
    .wordCount(wordCount), .memRdEn(memRdEn),
    .memAddr(memAddr), .memData(memData),
    .charOut(charOut), .charValid(charValid),
    .charReady(charReady), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Byte memory with one cycle of read latency.
  always @(posedge clock)
    if (memRdEn) memData <= mem[memAddr];

  initial forever begin
    @(posedge clock);
    #1;
    charReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_s(string nm, string act, string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\" want \"%s\"", nm, act, exp);
    end
  endtask

  // Expected text and read-address sequence for one dump.
  function automatic string model(input logic [15:0] off,
                                  input logic [15:0] pc,
                                  input logic [15:0] wc);
    string       t;
    logic [15:0] w;
    int          a;
    t = $sformatf("*%06o\n@%06o\n", off, pc);
    q_addr.delete();
    for (int i = 0; i < int'(wc); i++) begin
      a = (2 * i) % MSZ;
      w = {mem[a], mem[(a + 1) % MSZ]};
      t = {t, $sformatf("-%06o\n", w)};
      q_addr.push_back(a);
      q_addr.push_back((a + 1) % MSZ);
    end
    q_exp.delete();
    for (int k = 0; k < t.len(); k++) q_exp.push_back(t[k]);
    return t;
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(charValid), 1);
        chk("hold_char", 32'(charOut), 32'(prev_char));
      end
      if (charValid && charReady) begin
        if (q_exp.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_char: got %02h want none", charOut);
        end else begin
          chk("char", 32'(charOut), 32'(q_exp.pop_front()));
        end
      end
      if (memRdEn) begin
        if (q_addr.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_read: got %0h want none", memAddr);
        end else begin
          chk("rd_addr", 32'(memAddr), 32'(q_addr.pop_front()));
        end
      end
      if (done) done_cnt++;
      prev_stall = charValid && !charReady;
      prev_char  = charOut;
    end
  end

  task automatic chk_reset_vals(string nm);
    chk({nm, "_rden"}, 32'(memRdEn), 0);
    chk({nm, "_addr"}, 32'(memAddr), 0);
    chk({nm, "_char"}, 32'(charOut), 0);
    chk({nm, "_valid"}, 32'(charValid), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
  endtask

  task automatic run_dump(input logic [15:0] off,
                          input logic [15:0] pc,
                          input logic [15:0] wc,
                          input bit bpm, input int mid,
                          input int abort, input int exp_cyc,
                          output string t);
    int cyc;
    bit got;
    @(negedge clock);
    bp = bpm;
    done_cnt = 0;
    dataOffset = off; initPC = pc; wordCount = wc;
    t = model(off, pc, wc);
    start = 1;
    cyc = 0;
    got = 0;
    while (cyc < 20000 && !got) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        start = 0;
        chk("busy_first", 32'(busy), 1);
        chk("first_char", 32'(charOut), 32'h2A);
      end
      if (mid != 0 && cyc == mid) begin
        start = 1; dataOffset = 16'o777;
      end
      if (mid != 0 && cyc == mid + 1) start = 0;
      if (abort != 0 && cyc == abort) begin
        #2;
        reset = 1;
        q_exp.delete(); q_addr.delete();
        @(negedge clock);
        chk_reset_vals("abort");
        reset = 0;
        bp = 0;
        return;
      end
      if (done) got = 1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL done_timeout: got none want done");
    end else begin
      if (exp_cyc != 0) chk("done_cycle", cyc, exp_cyc);
      chk("busy_at_done", 32'(busy), 0);
    end
    bp = 0;
    repeat (2) @(negedge clock);
    chk("done_pulses", done_cnt, 1);
    chk("done_low", 32'(done), 0);
    chk("chars_left", q_exp.size(), 0);
    chk("reads_left", q_addr.size(), 0);
  endtask

  initial begin
    for (int k = 0; k < MSZ; k++) mem[k] = 8'(k * 37 + 11);
    mem[0] = 8'h15; mem[1] = 8'hC0;
    mem[2] = 8'hFF; mem[3] = 8'hFF;
    repeat (3) @(negedge clock);
    chk_reset_vals("reset");
    reset = 0;

    run_dump(16'o100, 16'o4, 16'd2, 0, 0, 0, 39, s);
    chk_s("basic_text", s,
          "*000100\n@000004\n-012700\n-177777\n");

    run_dump(16'o0, 16'o177776, 16'd0, 0, 0, 0, 17, s);
    chk_s("zero_text", s, "*000000\n@177776\n");

    run_dump(16'o100, 16'o4, 16'd2, 1, 0, 0, 0, s);

    run_dump(16'o100, 16'o4, 16'd2, 0, 0, 23, 0, s);
    run_dump(16'o100, 16'o4, 16'd2, 0, 0, 0, 39, s);

    run_dump(16'o100, 16'o4, 16'd2, 0, 20, 0, 39, s);

    run_dump(16'o123, 16'o456, 16'd129, 0, 0, 0,
             16 + 11 * 129 + 1, s);
    chk_s("wrap_last_line", s.substr(s.len() - 8, s.len() - 1),
          "-012700\n");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_image_writer.md
# load_image_writer

Serializes a loaded program image back into the team's ASCII load-file format: a `*` data-offset line, an `@` initial-PC line, then one `-` line per 16-bit word read from byte-wide program memory. Each value is six octal digits followed by newline. It sits beside `pdp_isa` on the memory read side and streams characters over a valid/ready handshake to a file-writer or UART sink. This allows a memory image to be dumped after execution and compared against the original load file.

## Interface
- ADDR_W, 16, byte-address width of program memory
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- dataOffset  in  16  value printed on `*` line; latched at start
- initPC  in  16  value printed on `@` line; latched at start
- wordCount  in  16  number of 16-bit words to dump; latched at start
- memRdEn  out  1  memory read strobe
- memAddr  out  ADDR_W  byte address; read data returns next cycle
- memData  in  8  read byte, valid the cycle after memRdEn
- charOut  out  8  ASCII character
- charValid  out  1  charOut valid
- charReady  in  1  sink accepts charOut when charValid && charReady
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the final newline is accepted

## Operation
- States: IDLE, HDR_SYM, HDR_DIG, HDR_NL, RD_HI, RD_LO, RD_WAIT, W_SYM, W_DIG, W_NL, FIN.
- IDLE + start: latch inputs, clear word index i and header select, then go to HDR_SYM.
- Header, pass 0 prints `*` + dataOffset. Header, pass 1 prints `@` + initPC. Each line is symbol, 6 digits, then 0x0A.
- After pass 1 NL is accepted:
  - wordCount==0: go to FIN.
  - otherwise: go to RD_HI.
- Word read sequence:
  - RD_HI: memRdEn=1, memAddr=2i.
  - RD_LO: memRdEn=1, memAddr=2i+1; capture memData as high byte.
  - RD_WAIT: capture memData as low byte.
- Word = {hi, lo}: even address is the high byte. This matches the loader's byte order.
- W_SYM emits `-`, W_DIG emits 6 digits, W_NL emits 0x0A. Then i++.
  - If i==wordCount: go to FIN.
  - Otherwise: go to RD_HI.
- Octal encoding, MSB first:
  - digit0 = value[15] (0 or 1).
  - Digits 1–5 = value[14:12], [11:9], [8:6], [5:3], [2:0].
  - charOut = 0x30 + digit.
- Address arithmetic is modulo 2^ADDR_W. wordCount > 2^(ADDR_W-1) wraps and re-reads from address 0; this is not an error.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- start while busy is ignored, with no effect on latched values.
- memRdEn is low in all states except RD_HI and RD_LO.

## Timing
- Reset values: memRdEn=0, memAddr=0, charOut=0, charValid=0, busy=0, done=0, state IDLE.
- Reset mid-dump: all outputs take reset values at that edge and any partial line is abandoned.
- start sampled at edge n: busy=1 and charValid=1 with charOut=`*` after edge n.
- charValid stays high in all SYM/DIG/NL states. charOut is held stable while charValid && !charReady.
  - Advance exactly one character per accepted transfer.
  - No combinational path from charReady to charValid.
- With charReady tied high:
  - Header: 16 cycles.
  - Each word: 3 read cycles + 8 characters = 11 cycles.
  - done asserts the cycle after the last NL handshake.
  - Total from start to done: 16 + 11·wordCount + 1 cycles.
- memData is sampled exactly one cycle after its address. The memory contents must not change during a dump.

## Test plan
- Basic dump:
  - Stimulus: dataOffset=0o000100, initPC=0o000004, wordCount=2, mem[0..3]=0x15,0xC0,0xFF,0xFF, ready high.
  - Required stream: "*000100\n@000004\n-012700\n-177777\n".
  - done at cycle 16+22+1 after start.
- Zero words:
  - Stimulus: wordCount=0, dataOffset=0, initPC=0o177776.
  - Required stream: "*000000\n@177776\n"; done 17 cycles after start; memRdEn never asserted.
- Backpressure:
  - Stimulus: basic dump with charReady toggling pseudo-randomly.
  - Required: identical character stream; charOut never changes while valid && !ready; no character dropped or duplicated.
- Reset mid-stream:
  - Stimulus: assert reset during the third digit of word 0; deassert, then start a new dump.
  - Required: all outputs at reset values the next cycle; the new dump begins cleanly with `*`.
- Start while busy:
  - Stimulus: pulse start with different dataOffset mid-dump.
  - Required: the stream is unchanged and exactly one done pulse occurs.
- Address wrap:
  - Stimulus: wordCount=0o100001 (32769).
  - Required: the last word is read from addresses 0x0000/0x0001 and its line equals the first word's line.
